// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and the digit-legality helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // A nibble is a legal BCD digit when it does not exceed 9.
  function automatic logic bcd_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the up/down counter. The digit advances only when the
// parent says a step is taken and every lower digit is at its roll point.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       up,
  input  logic       carry_in,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t ld_digit,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t digit_q, digit_d;

  assign digit  = digit_q;
  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == BCD_MIN);

  // Next digit value: clear, then load, then a carried step with 9<->0 roll.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = BCD_MIN;
    end else if (load) begin
      digit_d = ld_digit;
    end else if (step && carry_in) begin
      if (up) digit_d = at_max ? BCD_MIN : digit_q + 4'd1;
      else    digit_d = at_min ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= BCD_MIN;
    else        digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, checked parallel load,
// terminal-count and load-error pulses.
// Optional prescaler enabled by defining BCD_PRESCALE_EN.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SATURATE     = 0,
  parameter int PRESCALE_DIV = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tc,
  output logic                    load_err
);

  logic [NUM_DIGITS-1:0] at_max, at_min, carry;
  logic load_ok, load_acc, boundary, step_tick, step_req, step_cell;
  logic tc_q, tc_d, load_err_q, load_err_d;

  // Load is accepted only if every nibble is a legal digit.
  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!bcd_valid(load_val[4*k +: 4])) load_ok = 1'b0;
    end
  end

  assign load_acc = load & ~clr & load_ok;

  // Ripple carry: digit k moves only when all lower digits sit at the roll point.
  always_comb begin
    carry[0] = 1'b1;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      carry[k] = carry[k-1] & (up ? at_max[k-1] : at_min[k-1]);
    end
  end

  assign boundary = up ? (&at_max) : (&at_min);

`ifdef BCD_PRESCALE_EN
  localparam int PW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign step_tick = (presc_q == PS_LAST);

  // Prescaler advances on enabled cycles, wraps on the tick, restarts on clr/load.
  always_comb begin
    presc_d = presc_q;
    if (clr || load_acc) presc_d = '0;
    else if (en)         presc_d = step_tick ? '0 : presc_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end
`else
  logic unused_presc_div;
  assign unused_presc_div = ^PRESCALE_DIV;
  assign step_tick = 1'b1;
`endif

  // A rejected load still outranks stepping, so only one action lands per cycle.
  assign step_req   = en & step_tick & ~clr & ~load;
  assign step_cell  = step_req & ~((SATURATE != 0) & boundary);
  assign tc_d       = step_req & boundary;
  assign load_err_d = load & ~clr & ~load_ok;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (step_cell),
      .up       (up),
      .carry_in (carry[g]),
      .clr      (clr),
      .load     (load_acc),
      .ld_digit (load_val[4*g +: 4]),
      .digit    (count[4*g +: 4]),
      .at_max   (at_max[g]),
      .at_min   (at_min[g])
    );
  end

  // Registered single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule
